// File: rtl/rx_descrambler_ctrl_pkg.sv
// rx_ctrl_pkg: shared types and constants for the 802.11a receive descrambler sequencer.
package rx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_SERVICE,
        ST_PAYLOAD,
        ST_TAIL,
        ST_PAD
    } state_t;

    localparam int unsigned SEED_BITS    = 7;
    localparam int unsigned SERVICE_BITS = 16;
    localparam int unsigned TAIL_BITS    = 6;

    localparam int unsigned NUM_NDBPS = 8;
    localparam int unsigned LEGAL_NDBPS [NUM_NDBPS] = '{24, 36, 48, 72, 96, 144, 192, 216};

    // True when n is one of the 802.11a data-bits-per-symbol rates
    function automatic logic ndbps_is_legal(input int unsigned n);
        logic ok;
        ok = 1'b0;
        for (int unsigned i = 0; i < NUM_NDBPS; i++) begin
            if (LEGAL_NDBPS[i] == n) ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/rx_descrambler_ctrl_if.sv
// Bit-stream / descrambler control bundle for rx_descrambler_ctrl.
// slave: the sequencer side; master: the bit-stream source / descrambler side.
interface rx_descrambler_ctrl_if #(
    parameter int unsigned LEN_W   = 12,
    parameter int unsigned NDBPS_W = 8
) ();
    logic               Start;
    logic [LEN_W-1:0]   Length;
    logic [NDBPS_W-1:0] Ndbps;
    logic               InValid;
    logic               InBit;
    logic               DescrBit;
    logic               SeedLoad;
    logic [6:0]         Seed;
    logic               DescrEn;
    logic               PayloadValid;
    logic               Busy;
    logic               Done;
    logic               Error;

    modport slave (
        input  Start, Length, Ndbps, InValid, InBit, DescrBit,
        output SeedLoad, Seed, DescrEn, PayloadValid, Busy, Done, Error
    );

    modport master (
        output Start, Length, Ndbps, InValid, InBit, DescrBit,
        input  SeedLoad, Seed, DescrEn, PayloadValid, Busy, Done, Error
    );
endinterface

// File: rtl/rx_descrambler_ctrl_sym_counter.sv
// rx_sym_counter: mod-Ndbps counter of accepted DATA bits; Wrap marks the bit closing a symbol.
module rx_sym_counter #(
    parameter int unsigned NDBPS_W = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               i_clear,
    input  logic               i_adv,
    input  logic [NDBPS_W-1:0] i_ndbps,
    output logic               o_wrap
);
    logic [NDBPS_W-1:0] r_cnt;
    logic               w_last;

    assign w_last = (r_cnt == (i_ndbps - NDBPS_W'(1)));
    assign o_wrap = i_adv && w_last;

    // Count accepted bits modulo Ndbps; held at zero while no frame is active
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_adv) begin
            r_cnt <= w_last ? '0 : r_cnt + NDBPS_W'(1);
        end
    end

endmodule

// File: rtl/rx_descrambler_ctrl.sv
// rx_descrambler_ctrl: per-frame sequencer for the 802.11a receive descrambler.
// Recovers the seed from the first 7 SERVICE bits, then qualifies SERVICE,
// PAYLOAD, TAIL and PAD regions. Optional macro SERVICE_CHECK_EN enables
// checking that the 9 reserved SERVICE bits descramble to zero.
module rx_descrambler_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W   = 12,
    parameter int unsigned NDBPS_W = 8,
    parameter int unsigned CNT_W   = 15
) (
    input  logic                  Clock,
    input  logic                  Reset,
    rx_descrambler_ctrl_if.slave  bus
);
    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_len_bits;
    logic [NDBPS_W-1:0] r_ndbps;
    logic [5:0]         r_sr;
    logic [6:0]         r_seed;
    logic               r_done;
    logic               r_err;

    logic               w_acc;
    logic               w_wrap;
    logic               w_start_ok;
    logic               w_seed_load;
    logic               w_finish;
    logic               w_abort;
    logic [6:0]         w_new_seed;
    logic [LEN_W+2:0]   w_len_bits;

`ifdef SERVICE_CHECK_EN
    logic               r_svc_or;
`else
    logic               w_unused_descr;
    assign w_unused_descr = bus.DescrBit;
`endif

    assign w_acc      = bus.InValid && (r_state != ST_IDLE);
    assign w_start_ok = (bus.Length != '0) && ndbps_is_legal(32'(bus.Ndbps));
    assign w_new_seed = {r_sr, bus.InBit};
    assign w_len_bits = {bus.Length, 3'b000};

    rx_sym_counter #(.NDBPS_W(NDBPS_W)) u_sym (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_clear (r_state == ST_IDLE),
        .i_adv   (w_acc),
        .i_ndbps (r_ndbps),
        .o_wrap  (w_wrap)
    );

    // Next-state and region-end decode; each region closes on its last accepted bit
    always_comb begin
        w_next      = r_state;
        w_seed_load = 1'b0;
        w_finish    = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.Start && w_start_ok) w_next = ST_SEED;
            end
            ST_SEED: begin
                if (bus.InValid && r_cnt == CNT_W'(SEED_BITS - 1)) begin
                    if (w_new_seed == '0) begin
                        w_abort = 1'b1;
                        w_next  = ST_IDLE;
                    end else begin
                        w_seed_load = 1'b1;
                        w_next      = ST_SERVICE;
                    end
                end
            end
            ST_SERVICE: begin
                if (bus.InValid && r_cnt == CNT_W'(SERVICE_BITS - SEED_BITS - 1)) begin
`ifdef SERVICE_CHECK_EN
                    if (r_svc_or || bus.DescrBit) begin
                        w_abort = 1'b1;
                        w_next  = ST_IDLE;
                    end else begin
                        w_next  = ST_PAYLOAD;
                    end
`else
                    w_next = ST_PAYLOAD;
`endif
                end
            end
            ST_PAYLOAD: begin
                if (bus.InValid && r_cnt == r_len_bits - CNT_W'(1)) w_next = ST_TAIL;
            end
            ST_TAIL: begin
                if (bus.InValid && r_cnt == CNT_W'(TAIL_BITS - 1)) begin
                    // Tail landing on a symbol edge skips PAD entirely
                    if (w_wrap) begin
                        w_finish = 1'b1;
                        w_next   = ST_IDLE;
                    end else begin
                        w_next   = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                if (w_wrap) begin
                    w_finish = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register, per-region bit counter and frame parameters
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_len_bits <= '0;
            r_ndbps    <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) r_cnt <= '0;
            else if (w_acc)        r_cnt <= r_cnt + CNT_W'(1);
            if (r_state == ST_IDLE && bus.Start && w_start_ok) begin
                r_len_bits <= CNT_W'(w_len_bits);
                r_ndbps    <= bus.Ndbps;
            end
        end
    end

    // Seed shift register and held seed value
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_sr   <= '0;
            r_seed <= '0;
        end else begin
            if (r_state == ST_SEED && bus.InValid) r_sr <= w_new_seed[5:0];
            if (w_seed_load) r_seed <= w_new_seed;
        end
    end

    // Registered one-cycle Done / Error pulses
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_finish;
            r_err  <= w_abort || (r_state == ST_IDLE && bus.Start && !w_start_ok);
        end
    end

`ifdef SERVICE_CHECK_EN
    // OR of descrambled reserved SERVICE bits seen so far in this frame
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_svc_or <= 1'b0;
        end else if (r_state != ST_SERVICE) begin
            r_svc_or <= 1'b0;
        end else if (bus.InValid) begin
            r_svc_or <= r_svc_or || bus.DescrBit;
        end
    end
`endif

    assign bus.SeedLoad     = w_seed_load;
    assign bus.Seed         = w_seed_load ? w_new_seed : r_seed;
    assign bus.DescrEn      = bus.InValid && (r_state != ST_IDLE) && (r_state != ST_SEED);
    assign bus.PayloadValid = bus.InValid && (r_state == ST_PAYLOAD);
    assign bus.Busy         = (r_state != ST_IDLE);
    assign bus.Done         = r_done;
    assign bus.Error        = r_err;

endmodule
